// File: rtl/md_if.sv
// md_if: operand/command and HI/LO/busy bundle between EX stage and md_unit
interface md_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master(output start, op, a, b, input busy, hi, lo);
  modport slave(input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset,
  md_if.slave m
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [31:0] hi, hi_n, lo, lo_n, rh, rh_n, rl, rl_n;
  logic        wr, wr_n;
  logic        sx, sdiv, neg_a, neg_b;
  logic [63:0] prod;
  logic [31:0] da, db, dd, q, r;
  assign sx    = ~m.op[0];
  assign prod  = {{32{sx & m.a[31]}}, m.a} * {{32{sx & m.b[31]}}, m.b};
  assign sdiv  = m.op == 4'd2;
  assign neg_a = sdiv & m.a[31];
  assign neg_b = sdiv & m.b[31];
  assign da    = neg_a ? -m.a : m.a;
  assign db    = neg_b ? -m.b : m.b;
  assign dd    = db == 32'd0 ? 32'd1 : db;
  assign q     = da / dd;
  assign r     = da % dd;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    lo_n    = lo;
    rh_n    = rh;
    rl_n    = rl;
    wr_n    = wr;
    if (state == RUN) begin
      state_n = cnt == 16'd0 ? IDLE : RUN;
      cnt_n   = cnt == 16'd0 ? 16'd0 : cnt - 16'd1;
      hi_n    = cnt == 16'd0 && wr ? rh : hi;
      lo_n    = cnt == 16'd0 && wr ? rl : lo;
    end else if (m.start) begin
      if (m.op[3:2] == 2'b00) begin
        state_n = RUN;
        cnt_n   = m.op[1] ? 16'(DIV_CYCLES - 1) : 16'(MULT_CYCLES - 1);
        rh_n    = m.op[1] ? (neg_a ? -r : r) : prod[63:32];
        rl_n    = m.op[1] ? (neg_a ^ neg_b ? -q : q) : prod[31:0];
        wr_n    = !(m.op[1] && m.b == 32'd0);
      end
      hi_n = m.op == 4'd4 ? m.a : hi;
      lo_n = m.op == 4'd5 ? m.a : lo;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 16'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      rh    <= 32'd0;
      rl    <= 32'd0;
      wr    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi    <= hi_n;
      lo    <= lo_n;
      rh    <= rh_n;
      rl    <= rl_n;
      wr    <= wr_n;
    end
  end
  assign m.busy = state == RUN;
  assign m.hi   = hi;
  assign m.lo   = lo;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit against an arithmetic HI/LO model
module tb_md_unit;
  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;
  md_if bus();
  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut(.clk(clk), .reset(reset), .m(bus));
  typedef struct {int n; logic [31:0] oh, ol, h, l;} exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  logic [31:0] mh = 0;
  logic [31:0] ml = 0;
  bit skip = 0;
  int cyc = 0;
  bit wb = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    exp_t e;
    e.oh = mh;
    e.ol = ml;
    e.n = op[1] ? 10 : 5;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0: begin p = sa * sb; mh = p[63:32]; ml = p[31:0]; end
      4'd1: begin p = {32'b0, a} * {32'b0, b}; mh = p[63:32]; ml = p[31:0]; end
      4'd2: if (b != 0) begin mh = 32'(sa % sb); ml = 32'(sa / sb); end
      4'd3: if (b != 0) begin mh = a % b; ml = a / b; end
      4'd4: mh = a;
      4'd5: ml = a;
      default: ;
    endcase
    e.h = mh;
    e.l = ml;
    if (op < 4) q.push_back(e);
  endtask
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    if (!bus.busy) model(op, a, b);
    @(negedge clk);
    bus.start = 0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 40 && bus.busy; i++) @(negedge clk);
    chk("idle_timeout", bus.busy, 0);
  endtask
  always @(posedge clk) begin
    #1;
    if (bus.busy) begin
      cyc = wb ? cyc + 1 : 1;
      if (q.size() != 0) begin
        chk("hold_hi", bus.hi, q[0].oh);
        chk("hold_lo", bus.lo, q[0].ol);
      end
    end else if (wb) begin
      if (skip) skip = 0;
      else if (q.size() == 0) chk("done_without_op", q.size(), 1);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("busy_cycles", cyc, e.n);
        chk("done_hi", bus.hi, e.h);
        chk("done_lo", bus.lo, e.l);
      end
    end
    wb = bus.busy;
  end
  initial begin
    bus.start = 0;
    bus.op = 0;
    bus.a = 0;
    bus.b = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    issue(4'd7, 32'h1111, 32'h2222);
    chk("rsv_busy", bus.busy, 0);
    chk("rsv_hi", bus.hi, 0);
    chk("rsv_lo", bus.lo, 0);
    issue(4'd0, 32'hFFFFFFFF, 32'h2);
    wait_idle();
    chk("mult_hi", bus.hi, 32'hFFFFFFFF);
    chk("mult_lo", bus.lo, 32'hFFFFFFFE);
    issue(4'd1, 32'hFFFFFFFF, 32'h2);
    wait_idle();
    chk("multu_hi", bus.hi, 32'h1);
    chk("multu_lo", bus.lo, 32'hFFFFFFFE);
    issue(4'd2, 32'hFFFFFFF9, 32'h2);
    wait_idle();
    chk("div_hi", bus.hi, 32'hFFFFFFFF);
    chk("div_lo", bus.lo, 32'hFFFFFFFD);
    issue(4'd3, 32'h7, 32'h0);
    wait_idle();
    chk("divz_hi", bus.hi, 32'hFFFFFFFF);
    chk("divz_lo", bus.lo, 32'hFFFFFFFD);
    issue(4'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();
    chk("ovf_hi", bus.hi, 32'h0);
    chk("ovf_lo", bus.lo, 32'h80000000);
    issue(4'd4, 32'h1234, 32'h0);
    chk("mthi_busy", bus.busy, 0);
    chk("mthi_hi", bus.hi, 32'h1234);
    chk("mthi_lo", bus.lo, 32'h80000000);
    issue(4'd0, 32'd3, 32'd7);
    issue(4'd5, 32'h5, 32'h0);
    wait_idle();
    chk("mtlo_ignored_lo", bus.lo, 32'd21);
    chk("mtlo_ignored_hi", bus.hi, 32'd0);
    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      logic [31:0] a, b;
      int s;
      op = 4'($urandom_range(0, 7));
      a = $urandom;
      s = $urandom_range(0, 5);
      b = s == 0 ? 32'd0 : s == 1 ? 32'($urandom_range(1, 9)) : s == 2 ? 32'hFFFFFFFF : $urandom;
      if (s == 3) a = 32'h80000000;
      issue(op, a, b);
      if (op >= 4) begin
        chk("rnd_mt_busy", bus.busy, 0);
        chk("rnd_mt_hi", bus.hi, mh);
        chk("rnd_mt_lo", bus.lo, ml);
      end
      wait_idle();
    end
    issue(4'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", bus.busy, 1);
    reset = 0;
    skip = 1;
    q.delete();
    mh = 0;
    ml = 0;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_hi", bus.hi, 0);
    chk("abort_lo", bus.lo, 0);
    reset = 1;
    repeat (15) @(negedge clk);
    chk("late_busy", bus.busy, 0);
    chk("late_hi", bus.hi, 0);
    chk("late_lo", bus.lo, 0);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
